// File: rtl/cim_col_accum.sv
// Column-side shift-add accumulator for the CIM macro: sums per-beat column partial
// sums across row groups and bit planes (MSB first). Optional `SIGNED_INPUT_EN subtracts the MSB plane.
//
// state | meaning
// IDLE  | waiting for start, no beats accepted
// ACCUM | accepting psum beats, shift-adding per column
// DONE  | MAC complete, waiting for the output buffer to free up
module cim_col_accum #(
  parameter int NUM_COLS   = 16,
  parameter int PSUM_WIDTH = 4,
  parameter int NUM_GROUPS = 12,
  parameter int SEL_WIDTH  = 4,
  parameter int INPUT_BITS = 4,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             mac_on_pong_row,
  input  logic [SEL_WIDTH-1:0]             sel,
  input  logic                             psum_valid,
  output logic                             psum_ready,
  input  logic [NUM_COLS*PSUM_WIDTH-1:0]   psum,
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_COLS*ACC_WIDTH-1:0]    out_data,
  output logic                             out_row,
  output logic                             out_err
);

  localparam int GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int BIT_W = (INPUT_BITS > 1) ? $clog2(INPUT_BITS) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_GROUPS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(INPUT_BITS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc     [NUM_COLS];
  logic [ACC_WIDTH-1:0] acc_nxt [NUM_COLS];
  logic [GRP_W-1:0]     grp_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 err;
  logic                 cur_row;
  logic                 beat;
  logic                 sel_err;

  assign beat    = psum_valid & psum_ready;
  assign sel_err = (32'(sel) != 32'(grp_cnt));

  // The shift happens on the first group of each plane, so the previous plane gains weight x2.
  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
`ifdef SIGNED_INPUT_EN
      if (bit_cnt == '0)
        acc_nxt[c] = ((grp_cnt == '0) ? (acc[c] << 1) : acc[c])
                     - ACC_WIDTH'(psum[c*PSUM_WIDTH +: PSUM_WIDTH]);
      else
        acc_nxt[c] = ((grp_cnt == '0) ? (acc[c] << 1) : acc[c])
                     + ACC_WIDTH'(psum[c*PSUM_WIDTH +: PSUM_WIDTH]);
`else
      acc_nxt[c] = ((grp_cnt == '0) ? (acc[c] << 1) : acc[c])
                   + ACC_WIDTH'(psum[c*PSUM_WIDTH +: PSUM_WIDTH]);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      for (int c = 0; c < NUM_COLS; c++) acc[c] <= '0;
      grp_cnt    <= '0;
      bit_cnt    <= '0;
      err        <= 1'b0;
      cur_row    <= 1'b0;
      psum_ready <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            for (int c = 0; c < NUM_COLS; c++) acc[c] <= '0;
            grp_cnt    <= '0;
            bit_cnt    <= '0;
            err        <= 1'b0;
            cur_row    <= mac_on_pong_row;
            psum_ready <= 1'b1;
            busy       <= 1'b1;
            state      <= ACCUM;
          end
        end

        ACCUM: begin
          if (beat) begin
            for (int c = 0; c < NUM_COLS; c++) acc[c] <= acc_nxt[c];
            if (sel_err) err <= 1'b1;
            if (grp_cnt == GRP_LAST) begin
              grp_cnt <= '0;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt    <= '0;
                psum_ready <= 1'b0;
                state      <= DONE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              grp_cnt <= grp_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          // Reload overrides the drain-clear above when a handshake frees the buffer.
          if (!out_valid || out_ready) begin
            for (int c = 0; c < NUM_COLS; c++) out_data[c*ACC_WIDTH +: ACC_WIDTH] <= acc[c];
            out_row   <= cur_row;
            out_err   <= err;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_col_accum.sv
// Directed bench for cim_col_accum: vector table of MACs plus backpressure and
// mid-MAC reset sequences. Expected values follow SIGNED_INPUT_EN when defined.
module tb_cim_col_accum;

  localparam int NC = 16;
  localparam int PW = 4;
  localparam int AW = 16;
`ifdef SIGNED_INPUT_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              mac_on_pong_row = 1'b0;
  logic [3:0]        sel = '0;
  logic              psum_valid = 1'b0;
  logic              psum_ready;
  logic [NC*PW-1:0]  psum = '0;
  logic              busy;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [NC*AW-1:0]  out_data;
  logic              out_row;
  logic              out_err;

  int tests = 0;
  int fails = 0;

  cim_col_accum dut (
    .clk(clk), .rst(rst), .start(start), .mac_on_pong_row(mac_on_pong_row),
    .sel(sel), .psum_valid(psum_valid), .psum_ready(psum_ready), .psum(psum),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v0;     // col0 psum value
    logic [3:0]  vr;     // psum value for columns 1..15
    int          plane;  // -1: every beat; else only group 0 of this plane
    int          bad;    // beat index carrying sel=7, -1 none
    logic        row;
    logic [15:0] e0;
    logic [15:0] er;
    logic        eerr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NC*PW-1:0] build(input int b, input logic [3:0] v0,
                                              input logic [3:0] vr, input int plane);
    logic [NC*PW-1:0] p;
    bit act;
    act = (plane < 0) || ((b / 12) == plane && (b % 12) == 0);
    p = '0;
    for (int c = 0; c < NC; c++)
      p[c*PW +: PW] = act ? ((c == 0) ? v0 : vr) : 4'd0;
    return p;
  endfunction

  function automatic logic [15:0] rest_val(input logic [15:0] er);
    logic [15:0] r;
    r = er;
    for (int c = 1; c < NC; c++)
      if (out_data[c*AW +: AW] !== er) r = out_data[c*AW +: AW];
    return r;
  endfunction

  // Returns at the negedge after the last accepted beat (block is in DONE).
  task automatic send_mac(input int nbeats, input logic [3:0] v0, input logic [3:0] vr,
                          input int plane, input int bad, input logic row);
    int guard;
    @(negedge clk);
    start = 1'b1;
    mac_on_pong_row = row;
    @(negedge clk);
    start = 1'b0;
    mac_on_pong_row = ~row;
    for (int b = 0; b < nbeats; b++) begin
      if (b == 10) begin
        // stall with garbage data and a start that must be ignored
        psum_valid = 1'b0;
        psum = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
      end
      psum_valid = 1'b1;
      sel = (b == bad) ? 4'd7 : 4'(b % 12);
      psum = build(b, v0, vr, plane);
      guard = 0;
      while (!psum_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!psum_ready) begin
        chk("psum_ready_timeout", 32'(psum_ready), 32'd1);
        psum_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    psum_valid = 1'b0;
    psum = '0;
  endtask

  initial begin
    vecs[0] = '{4'd1,  4'd0,  -1, -1, 1'b1, SGN ? 16'hFFF4 : 16'd180,  16'd0, 1'b0};
    vecs[1] = '{4'd12, 4'd12, -1, -1, 1'b0, SGN ? 16'hFF70 : 16'd2160,
                SGN ? 16'hFF70 : 16'd2160, 1'b0};
    vecs[2] = '{4'd1,  4'd0,  -1,  5, 1'b0, SGN ? 16'hFFF4 : 16'd180,  16'd0, 1'b1};
    vecs[3] = '{4'd1,  4'd0,  -1, -1, 1'b1, SGN ? 16'hFFF4 : 16'd180,  16'd0, 1'b0};
    vecs[4] = '{4'd1,  4'd0,   0, -1, 1'b0, SGN ? 16'hFFF8 : 16'd8,    16'd0, 1'b0};
    vecs[5] = '{4'd5,  4'd3,   1, -1, 1'b1, 16'd20, 16'd12, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_psum_ready", 32'(psum_ready), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_out_valid",  32'(out_valid), 0);
    chk("rst_out_data",   32'(|out_data), 0);
    chk("rst_out_row",    32'(out_row), 0);
    chk("rst_out_err",    32'(out_err), 0);
    rst = 1'b0;

    // vector table, out_ready held high
    for (int i = 0; i < 6; i++) begin
      send_mac(48, vecs[i].v0, vecs[i].vr, vecs[i].plane, vecs[i].bad, vecs[i].row);
      chk($sformatf("v%0d_busy_done", i),  32'(busy), 1);
      chk($sformatf("v%0d_lat_n1", i),     32'(out_valid), 0);
      @(negedge clk);
      chk($sformatf("v%0d_lat_n2", i),     32'(out_valid), 1);
      chk($sformatf("v%0d_col0", i),       32'(out_data[0 +: AW]), 32'(vecs[i].e0));
      chk($sformatf("v%0d_rest", i),       32'(rest_val(vecs[i].er)), 32'(vecs[i].er));
      chk($sformatf("v%0d_err", i),        32'(out_err), 32'(vecs[i].eerr));
      chk($sformatf("v%0d_row", i),        32'(out_row), 32'(vecs[i].row));
      chk($sformatf("v%0d_busy_idle", i),  32'(busy), 0);
      @(negedge clk);
      chk($sformatf("v%0d_drained", i),    32'(out_valid), 0);
    end

    // backpressure: A held, B completes and waits in DONE
    out_ready = 1'b0;
    send_mac(48, 4'd1, 4'd0, -1, -1, 1'b1);
    repeat (2) @(negedge clk);
    chk("bp_a_valid", 32'(out_valid), 1);
    send_mac(48, 4'd2, 4'd2, -1, -1, 1'b0);
    repeat (3) @(negedge clk);
    chk("bp_hold_busy",       32'(busy), 1);
    chk("bp_hold_psum_ready", 32'(psum_ready), 0);
    chk("bp_hold_valid",      32'(out_valid), 1);
    chk("bp_hold_col0",       32'(out_data[0 +: AW]), SGN ? 32'hFFF4 : 32'd180);
    chk("bp_hold_row",        32'(out_row), 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_valid", 32'(out_valid), 1);
    chk("bp_b_col0",  32'(out_data[0 +: AW]), SGN ? 32'hFFE8 : 32'd360);
    chk("bp_b_rest",  32'(rest_val(SGN ? 16'hFFE8 : 16'd360)), SGN ? 32'hFFE8 : 32'd360);
    chk("bp_b_row",   32'(out_row), 0);
    chk("bp_b_busy",  32'(busy), 0);
    @(negedge clk);
    chk("bp_b_drained", 32'(out_valid), 0);

    // reset mid-MAC with a result still buffered
    out_ready = 1'b0;
    send_mac(48, 4'd1, 4'd0, -1, -1, 1'b1);
    repeat (2) @(negedge clk);
    chk("mr_buffered", 32'(out_valid), 1);
    send_mac(20, 4'd1, 4'd0, -1, -1, 1'b1);
    chk("mr_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mr_out_valid",  32'(out_valid), 0);
    chk("mr_out_data",   32'(|out_data), 0);
    chk("mr_out_row",    32'(out_row), 0);
    chk("mr_busy",       32'(busy), 0);
    chk("mr_psum_ready", 32'(psum_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send_mac(48, 4'd1, 4'd0, -1, -1, 1'b0);
    @(negedge clk);
    chk("mr_fresh_valid", 32'(out_valid), 1);
    chk("mr_fresh_col0",  32'(out_data[0 +: AW]), SGN ? 32'hFFF4 : 32'd180);
    chk("mr_fresh_err",   32'(out_err), 0);
    chk("mr_fresh_row",   32'(out_row), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
